// File: rtl/pipe_defs.sv
// Shared definitions for the OpenMIPS pipeline control unit.
// Holds the contiguous stall patterns, the exception type codes delivered
// by the mem stage, and the control FSM state encoding.
package pipe_defs;

    // Stall patterns, bit0 = pc ... bit7 = wb. Every pattern is contiguous
    // from bit0. The register just above the highest held stage therefore
    // sees stall[n]=1, stall[n+1]=0 and inserts the bubble itself.
    localparam logic [7:0] STALL_NONE = 8'b0000_0000;
    localparam logic [7:0] STALL_IF   = 8'b0000_0011;
    localparam logic [7:0] STALL_ID   = 8'b0000_0111;
    localparam logic [7:0] STALL_EX   = 8'b0000_1111;
    localparam logic [7:0] STALL_MEM  = 8'b0111_1111;

    // Final exception types from the mem stage (0 = none)
    localparam logic [31:0] EXC_INT  = 32'h0000_0001;
    localparam logic [31:0] EXC_SYS  = 32'h0000_0008;
    localparam logic [31:0] EXC_BRK  = 32'h0000_0009;
    localparam logic [31:0] EXC_RI   = 32'h0000_000a;
    localparam logic [31:0] EXC_OV   = 32'h0000_000c;
    localparam logic [31:0] EXC_TR   = 32'h0000_000d;
    localparam logic [31:0] EXC_ERET = 32'h0000_000e;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_BUSERR,
        ST_DRAIN
    } state_t;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Pipeline control bundle between the stages and pipe_ctrl.
// Stage side : stallreq_if/id/ex/mem, excepttype, cp0_epc, stat_clr
// Control side: stall[7:0], flush, new_pc, bus_abort, bus_err, stall_cycles
// master = pipe_ctrl, slave = pipeline / memory interface.
interface pipe_ctrl_if;

    logic        stallreq_if;
    logic        stallreq_id;
    logic        stallreq_ex;
    logic        stallreq_mem;
    logic [31:0] excepttype;
    logic [31:0] cp0_epc;
    logic        stat_clr;
    logic [7:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        bus_abort;
    logic        bus_err;
    logic [31:0] stall_cycles;

    modport master (
        input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
        input  excepttype, cp0_epc, stat_clr,
        output stall, flush, new_pc, bus_abort, bus_err, stall_cycles
    );

    modport slave (
        output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
        output excepttype, cp0_epc, stat_clr,
        input  stall, flush, new_pc, bus_abort, bus_err, stall_cycles
    );

endinterface

// File: rtl/bus_watchdog.sv
// Memory bus hang detector.
// Counts consecutive stallreq_mem cycles while the control FSM is in RUN
// with no exception pending, and flags timeout_hit in the cycle the count
// reaches TIMEOUT-1 (so TIMEOUT=1 fires on the first wait cycle).
// Ports: clk, rst (async, active-high), run (FSM in RUN), mem_req,
//        exc_pending, timeout_hit (combinational).
module bus_watchdog #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic mem_req,
    input  logic exc_pending,
    output logic timeout_hit
);

    localparam logic [15:0] LIMIT = 16'(TIMEOUT - 1);

    logic [15:0] count;

    assign timeout_hit = run && mem_req && !exc_pending && (count == LIMIT);

    // Any break in the wait (exception, non-RUN state, request dropped)
    // or a fired timeout restarts the count from zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (!run || !mem_req || exc_pending || timeout_hit) begin
            count <= '0;
        end else begin
            count <= count + 16'd1;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Central pipeline control for the 8-stage OpenMIPS pipeline.
// Merges stage stall requests into one contiguous stall vector (deepest
// requester wins), flushes and redirects on exceptions/eret, aborts a hung
// memory bus via bus_watchdog, and counts stalled cycles (saturating).
// Ports: clk, rst (async, active-high), bus (pipe_ctrl_if.master).
// Parameters: TIMEOUT (bus wait limit, 1..65535), EXC_VEC (exception PC).
module pipe_ctrl
    import pipe_defs::*;
#(
    parameter int unsigned TIMEOUT = 255,
    parameter logic [31:0] EXC_VEC = 32'h0000_0020
) (
    input  logic         clk,
    input  logic         rst,
    pipe_ctrl_if.master  bus
);

    state_t      state;
    state_t      state_next;
    logic        exc_pending;
    logic        timeout_hit;
    logic [7:0]  stall_req;
    logic [7:0]  stall_c;
    logic        flush_c;
    logic [31:0] exc_target;
    logic [31:0] new_pc_c;
    logic [31:0] stall_cnt;

    assign exc_pending = (bus.excepttype != 32'd0);

    bus_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk         (clk),
        .rst         (rst),
        .run         (state == ST_RUN),
        .mem_req     (bus.stallreq_mem),
        .exc_pending (exc_pending),
        .timeout_hit (timeout_hit)
    );

    // Deepest requester wins; patterns are never OR-merged.
    always_comb begin
        stall_req = STALL_NONE;
        if (bus.stallreq_mem)     stall_req = STALL_MEM;
        else if (bus.stallreq_ex) stall_req = STALL_EX;
        else if (bus.stallreq_id) stall_req = STALL_ID;
        else if (bus.stallreq_if) stall_req = STALL_IF;
    end

    // Only eret redirects to EPC; every other cause enters the common vector.
    always_comb begin
        exc_target = EXC_VEC;
        case (bus.excepttype)
            EXC_ERET: exc_target = bus.cp0_epc;
            EXC_INT, EXC_SYS, EXC_BRK,
            EXC_RI, EXC_OV, EXC_TR: exc_target = EXC_VEC;
            default: exc_target = EXC_VEC;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_RUN;
        else     state <= state_next;
    end

    // An exception in RUN outranks both stalls and a simultaneous timeout.
    // DRAIN ignores requests and exceptions for one cycle while the memory
    // interface drops its access.
    always_comb begin
        state_next = state;
        stall_c    = STALL_NONE;
        flush_c    = 1'b0;
        new_pc_c   = 32'd0;
        case (state)
            ST_RUN: begin
                if (exc_pending) begin
                    flush_c  = 1'b1;
                    new_pc_c = exc_target;
                end else begin
                    stall_c = stall_req;
                    if (timeout_hit) state_next = ST_BUSERR;
                end
            end
            ST_BUSERR: begin
                flush_c    = 1'b1;
                new_pc_c   = EXC_VEC;
                state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                state_next = ST_RUN;
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase
    end

    // Combinational outputs are forced to zero while rst is held.
    assign bus.stall     = rst ? 8'd0  : stall_c;
    assign bus.flush     = rst ? 1'b0  : flush_c;
    assign bus.new_pc    = rst ? 32'd0 : new_pc_c;
    assign bus.bus_abort = (state == ST_BUSERR) || (state == ST_DRAIN);
    assign bus.bus_err   = (state == ST_BUSERR);

    // stat_clr beats the increment; the count sticks at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= 32'd0;
        end else if (bus.stat_clr) begin
            stall_cnt <= 32'd0;
        end else if (stall_c[0] && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign bus.stall_cycles = stall_cnt;

endmodule
